// File: rtl/vga_text_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_text_mem_arbiter
//
// Shares one single-port character RAM between the VGA text scan-out and a
// writer (screen update logic). The scan side prefetches the character code
// of the next 8x16 cell, so it is ready in char_next when the beam crosses
// the cell boundary. Writer requests are served in the free clocks between
// fetches through a req/ack handshake. Scan fetches always have priority.
//
// Ports
//   clk         system clock (pixel_tick arrives at most once per 4 clk)
//   reset       asynchronous, active-low reset
//   pixel_tick  one-clock pixel enable from the sync generator
//   video_on    active-area flag from the sync generator
//   pixel_x     current column counter (0..H_TOTAL-1)
//   pixel_y     current line counter (0..V_TOTAL-1)
//   wr_req      writer request, held until wr_ack
//   wr_addr     write address, stable while wr_req=1
//   wr_data     write data, stable while wr_req=1
//   wr_ack      one-clock pulse in the cycle the write is performed
//   mem_en      RAM enable
//   mem_we      RAM write enable
//   mem_addr    RAM address
//   mem_wdata   RAM write data
//   mem_rdata   RAM read data, valid one clock after a read enable
//   char_code   character code of the current cell
//   char_valid  char_code belongs to a visible text cell
//   overrun     sticky flag: a fetch trigger hit a still-pending fetch
// ---------------------------------------------------------------------------
module vga_text_mem_arbiter #(
   parameter int ADDR_W        = 12,
   parameter int DATA_W        = 8,
   parameter int COLS          = 80,
   parameter int ROWS          = 30,
   parameter int H_TOTAL       = 800,
   parameter int V_TOTAL       = 525,
   parameter int PRE_X         = 792,
   parameter int FETCH_PHASE   = 6,
   parameter int WR_BLANK_ONLY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pixel_tick,
   input  logic              video_on,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] char_code,
   output logic              char_valid,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN_RD,
      SCAN_CAP,
      WR
   } state_t;

   state_t              state;
   logic                scan_pend;
   logic                scan_stale;
   logic                scan_inrange;
   logic                cap_valid;
   logic [ADDR_W-1:0]   scan_addr;
   logic [DATA_W-1:0]   char_next;
   logic                next_valid;

   logic [31:0]         col_a;
   logic [31:0]         y_next;
   logic [31:0]         trig_row;
   logic [31:0]         trig_col;
   logic [ADDR_W-1:0]   trig_addr;
   logic                trig_a;
   logic                trig_b;
   logic                trig_fire;
   logic                trig_inrange;
   logic                cell_tick;
   logic                wr_allowed;

   // Work out whether this pixel tick requests a fetch and which cell it is
   // for. Two sources exist: the in-line prefetch of the cell to the right of
   // the current one, and the h-blank prefetch of column 0 of the next line,
   // which has to wrap the line counter at the end of the frame. Row and
   // column math is done 32 bits wide so the range test sees the true row
   // before the linear address is cut down to the RAM width.
   always_comb begin
      col_a  = 32'(pixel_x[9:3]) + 32'd1;
      y_next = (pixel_y == 10'(V_TOTAL - 1)) ? 32'd0 : 32'(pixel_y) + 32'd1;
      trig_a = (pixel_x[2:0] == 3'(FETCH_PHASE)) && (col_a < 32'(COLS));
      trig_b = (pixel_x == 10'(PRE_X));
      if (trig_b) begin
         trig_row = y_next >> 4;
         trig_col = 32'd0;
      end else begin
         trig_row = 32'(pixel_y[9:4]);
         trig_col = col_a;
      end
      trig_addr    = ADDR_W'(trig_row * 32'(COLS) + trig_col);
      trig_inrange = (trig_row < 32'(ROWS));
      trig_fire    = pixel_tick && (trig_a || trig_b);
   end

   // The cell boundary is the last pixel of each 8-pixel cell, plus the last
   // pixel of the line in case H_TOTAL is not a multiple of 8. Writes may be
   // restricted to the blanking interval so they never disturb the display.
   always_comb begin
      cell_tick  = pixel_tick &&
                   (((pixel_x[2:0] == 3'd7) && (pixel_x < 10'(H_TOTAL - 1))) ||
                    (pixel_x == 10'(H_TOTAL - 1)));
      wr_allowed = (WR_BLANK_ONLY == 0) || !video_on;
   end

   // Arbiter FSM together with the scan bookkeeping. A trigger latches the
   // fetch address and marks it pending; a trigger that finds the previous
   // fetch still pending replaces it and raises the sticky overrun flag.
   // In IDLE a trigger arriving in the same clock as a write request goes to
   // the scan first, so the write never pushes a fetch past its cell.
   // If a trigger lands while the RAM read is already on the bus, the data
   // coming back belongs to the old address, so the fetch is kept pending and
   // redone. Out-of-range rows walk through the same states without enabling
   // the RAM and leave a blank, invalid cell behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         scan_pend    <= 1'b0;
         scan_stale   <= 1'b0;
         scan_inrange <= 1'b0;
         cap_valid    <= 1'b0;
         scan_addr    <= '0;
         char_next    <= '0;
         next_valid   <= 1'b0;
         char_code    <= '0;
         char_valid   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (cell_tick) begin
            char_code  <= char_next;
            char_valid <= next_valid;
            next_valid <= 1'b0;
         end

         if (trig_fire) begin
            scan_addr    <= trig_addr;
            scan_inrange <= trig_inrange;
            if (scan_pend) begin
               overrun <= 1'b1;
            end
         end

         if (trig_fire) begin
            scan_pend <= 1'b1;
         end else if ((state == SCAN_CAP) && !scan_stale) begin
            scan_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (scan_pend || trig_fire) begin
                  state <= SCAN_RD;
               end else if (wr_req && wr_allowed) begin
                  state <= WR;
               end
            end
            SCAN_RD: begin
               cap_valid  <= scan_inrange;
               scan_stale <= trig_fire;
               state      <= SCAN_CAP;
            end
            SCAN_CAP: begin
               char_next  <= cap_valid ? mem_rdata : '0;
               next_valid <= cap_valid;
               scan_stale <= 1'b0;
               state      <= IDLE;
            end
            WR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM controls are decoded straight from the state register, so a reset
   // in the middle of a write removes the enable and the ack immediately.
   always_comb begin
      mem_en    = ((state == SCAN_RD) && scan_inrange) || (state == WR);
      mem_we    = (state == WR);
      wr_ack    = (state == WR);
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == WR) begin
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else if ((state == SCAN_RD) && scan_inrange) begin
         mem_addr = scan_addr;
      end
   end

endmodule
